// File: rtl/gray_conv_pkg.sv
// Shared encodings for the Gray-code conversion scheduler.
package gray_conv_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RESULT = 1'b1
    } state_t;

    localparam logic DIR_B2G = 1'b0;
    localparam logic DIR_G2B = 1'b1;

endpackage

// File: rtl/gray_conv_unit.sv
// Combinational binary<->Gray converter shared by all requesters.
module gray_conv_unit
    import gray_conv_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] in,
    input  logic             dir,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] gray;
    logic [WIDTH-1:0] bin;

    // Binary to Gray: each bit XORed with its upper neighbour.
    assign gray = in ^ (in >> 1);

    // Gray to binary: running XOR from the MSB downwards.
    always_comb begin
        logic acc;
        bin = '0;
        acc = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc    = acc ^ in[i];
            bin[i] = acc;
        end
    end

    assign out = (dir == DIR_G2B) ? bin : gray;

endmodule

// File: rtl/gray_conv_sched.sv
// Round-robin scheduler sharing one Gray-code converter among N_REQ requesters.
module gray_conv_sched
    import gray_conv_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       dir,
    input  logic [N_REQ*WIDTH-1:0] op_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [ID_W-1:0]        out_id,
    output logic                   out_dir,
    output logic                   busy
);

    state_t           state;
    logic [ID_W-1:0]  last_id;
    logic [ID_W-1:0]  idx;
    logic [ID_W-1:0]  win;
    logic             found;
    logic [WIDTH-1:0] op_sel;
    logic             dir_sel;
    logic [WIDTH-1:0] conv_out;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((32'(last_id) + k) % N_REQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Winner operand and direction mux feeding the shared converter.
    always_comb begin
        op_sel  = '0;
        dir_sel = DIR_B2G;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (win == ID_W'(i)) begin
                op_sel  = op_in[i*WIDTH +: WIDTH];
                dir_sel = dir[i];
            end
        end
    end

    gray_conv_unit #(
        .WIDTH(WIDTH)
    ) u_conv (
        .in (op_sel),
        .dir(dir_sel),
        .out(conv_out)
    );

    // One-cycle grant pulse in the capture cycle; never during reset or RESULT.
    always_comb begin
        gnt = '0;
        if (!rst && state == ST_IDLE && found) begin
            gnt[win] = 1'b1;
        end
    end

    // Control FSM with registered result, handshake and pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_dir   <= 1'b0;
            busy      <= 1'b0;
            last_id   <= ID_W'(N_REQ - 1);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        out_data  <= conv_out;
                        out_id    <= win;
                        out_dir   <= dir_sel;
                        last_id   <= win;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_RESULT;
                    end
                end
                ST_RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gray_conv_sched.md
Name: gray_conv_sched

Overview:
- Round-robin scheduler that shares one Gray-code conversion unit among N_REQ requesters.
- Each requester presents a WIDTH-bit operand and a direction bit: binary->Gray, or Gray->binary.
- The block arbitrates, captures the winning operand, converts it through one shared combinational unit, and returns a registered result with the requester ID.
- Output uses a valid/ready handshake and supports backpressure.
- Sits between requester blocks and the code-converter datapath.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 4, operand/result width in bits.
- ID_W, $clog2(N_REQ), width of the requester ID field.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester request; held until its gnt bit is seen.
- dir  in  N_REQ  per-requester direction: 0 = bin->Gray, 1 = Gray->bin.
- op_in  in  N_REQ*WIDTH  packed operands; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant pulse, one cycle, in the capture cycle.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  converted result.
- out_id  out  ID_W  index of the requester that owns out_data.
- out_dir  out  1  direction used for out_data.
- busy  out  1  high while in state RESULT.

Behaviour:
- Reset:
  - Synchronous and active-high; takes priority over everything else.
  - Next state is IDLE; out_valid=0, out_data=0, out_id=0, out_dir=0, busy=0.
  - Round-robin pointer last_id = N_REQ-1, so requester 0 wins first after reset.
  - gnt=0 while rst is high.
- FSM, two states:
  - IDLE:
    - If req==0, stay in IDLE; gnt=0.
    - Otherwise the winner is the first set req bit searching last_id+1, last_id+2, ... with wrap modulo N_REQ.
    - gnt[winner]=1, combinational, this cycle only.
    - At the clock edge: out_data <= conv(op_in[winner], dir[winner]); out_id <= winner; out_dir <= dir[winner]; last_id <= winner; go to RESULT.
  - RESULT:
    - out_valid=1 and busy=1; out_data, out_id and out_dir are stable.
    - If out_ready=1 at the edge, go to IDLE; otherwise hold.
    - No grant is issued in RESULT (gnt=0), even if req is high.
- Latency and throughput:
  - Result is visible 1 cycle after the grant cycle.
  - Minimum spacing is 2 cycles per conversion: grant, then accept.
  - out_valid falls the cycle after acceptance.
- Conversion (in the shared unit):
  - bin->Gray: g[W-1]=b[W-1]; g[i]=b[i+1]^b[i].
  - Gray->bin: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] (prefix-XOR from the MSB).
  - Purely combinational; no width growth.
- Fairness: a requester that keeps req high is served at most once per N_REQ grants while others are pending.
- Boundary conditions:
  - All requesters active: service order is 0,1,2,3,0,... from reset.
  - Single requester holding req continuously: served every 2 cycles when out_ready is tied high.
  - Requester drops req before being granted: no grant, no state change for it.
  - req bit set while in RESULT: ignored until IDLE; the data must still be held by the requester.
  - out_ready high while out_valid is low: no effect.
  - Reset asserted in RESULT: the pending result is discarded and out_valid=0 the next cycle; last_id returns to N_REQ-1.
  - All-zero operand converts to all-zero in both directions.
  - All-ones operand: bin->Gray gives 1000 (WIDTH=4); Gray->bin gives 1010.

Decomposition:
- Package gray_conv_pkg holds:
  - state encoding constants: ST_IDLE=1'b0, ST_RESULT=1'b1;
  - direction constants: DIR_B2G=1'b0, DIR_G2B=1'b1.
- One sub-module, gray_conv_unit(WIDTH): combinational, inputs in[WIDTH], dir; output out[WIDTH].
  - Instantiated once and fed by the winner mux.
  - Testable standalone against the existing bin->Gray converter for dir=0.

Test Plan:
- Reset, then req=0001, op0=1011, dir0=0 -> gnt=0001 in cycle 1; cycle 2 out_valid=1, out_data=1110, out_id=0, out_dir=0.
- req=0010, op1=1110, dir1=1, out_ready=1 -> out_data=1011, out_id=1; out_valid high exactly one cycle.
- req=1111 held, out_ready=1, ops 0110/1111/0000/1000, all dir=0 -> grants 0,1,2,3,0 every 2 cycles; out_data 0101, 1000, 0000, 1100 in order.
- Backpressure: result 0101 pending, out_ready=0 for 5 cycles -> out_valid, out_data and out_id stable; gnt stays 0 despite req=1110; after out_ready=1, next grant goes to requester 1.
- Reset asserted in RESULT with out_valid=1 -> next cycle out_valid=0 and busy=0; with req=1111 the first grant afterwards is 0001.
- Exhaustive: for all 16 operands and both dir values through requester 2 -> Gray->bin(bin->Gray(x)) round-trip equals x; out_id=2 throughout.
